seq_sub32: RTL

//  Multi-cycle chunk-serial subtractor: diff = a - b - borrow_in, the inverse operation of the
//  32-bit ripple-carry adder. Processes CHUNK bits per cycle LSB-first, rippling the borrow

---
 rtl/alu_pkg.sv | 12 +
 rtl/sub_chunk.sv | 22 ++
 rtl/seq_sub32.sv | 135 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types and widths
package alu_pkg;

  typedef enum logic [1:0] {
    SUB_IDLE,
    SUB_BUSY,
    SUB_DONE
  } sub_state_t;

  localparam int DATA_W = 32;

endpackage

// File: rtl/sub_chunk.sv
// rtl/sub_chunk.sv - W-bit combinational subtractor with borrow in/out
module sub_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_c,
  input  logic [W-1:0] b_c,
  input  logic         bi,
  output logic [W-1:0] d,
  output logic         bo
);

  logic [W:0] full;

  // Zero-extended W+1 bit subtraction; the top bit is the borrow out.
  always_comb begin
    full = {1'b0, a_c} - {1'b0, b_c} - {{W{1'b0}}, bi};
  end

  assign d  = full[W-1:0];
  assign bo = full[W];

endmodule

// File: rtl/seq_sub32.sv
// rtl/seq_sub32.sv - chunk-serial subtractor with valid/ready handshakes
module seq_sub32
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("seq_sub32: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             bo_q, bo_d;
  logic             ov_q, ov_d;

  logic [CHUNK-1:0] c_a, c_b, c_d;
  logic             c_bo;
  logic             last;

  // Operands are shifted right each BUSY cycle, so the active chunk is always the low slice.
  assign c_a  = a_q[CHUNK-1:0];
  assign c_b  = b_q[CHUNK-1:0];
  assign last = (cnt_q == LAST);

  sub_chunk #(.W(CHUNK)) u_chunk (
    .a_c (c_a),
    .b_c (c_b),
    .bi  (borrow_q),
    .d   (c_d),
    .bo  (c_bo)
  );

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= SUB_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bo_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      bo_q     <= bo_d;
      ov_q     <= ov_d;
    end
  end

  // Next-state: accept in IDLE, run NCHUNK BUSY cycles, hold DONE until consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SUB_IDLE: if (in_valid)  state_d = SUB_BUSY;
      SUB_BUSY: if (last)      state_d = SUB_DONE;
      SUB_DONE: if (out_ready) state_d = SUB_IDLE;
      default:                 state_d = SUB_IDLE;
    endcase
  end

  // Datapath: capture operands, then fold one chunk per cycle into the top of diff.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    bo_d     = bo_q;
    ov_d     = ov_q;
    case (state_q)
      SUB_IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = borrow_in;
          cnt_d    = '0;
        end
      end
      SUB_BUSY: begin
        a_d      = a_q >> CHUNK;
        b_d      = b_q >> CHUNK;
        borrow_d = c_bo;
        diff_d   = (diff_q >> CHUNK) | (WIDTH'(c_d) << (WIDTH - CHUNK));
        cnt_d    = last ? '0 : cnt_q + 1'b1;
        if (last) begin
          bo_d = c_bo;
          ov_d = (c_a[CHUNK-1] != c_b[CHUNK-1]) && (c_d[CHUNK-1] != c_a[CHUNK-1]);
        end
      end
      default: ;
    endcase
  end

  // Handshake outputs decode directly from the state.
  always_comb begin
    in_ready  = (state_q == SUB_IDLE);
    out_valid = (state_q == SUB_DONE);
  end

  assign diff       = diff_q;
  assign borrow_out = bo_q;
  assign overflow   = ov_q;

endmodule
